// File: rtl/twiddle_sequencer.sv
// Twiddle-factor sequencer for a radix-2 FFT.
// Walks every stage/butterfly pair, fetches the twiddle from a ROM with a
// one-cycle registered read, and presents it to the butterfly over a
// valid/ready handshake tagged with stage, butterfly and last.
// Optional build macro: TWIDDLE_CONJ_EN adds i_inverse, which conjugates the
// twiddle (saturating negate of the imaginary part) for inverse transforms.
module twiddle_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned I = 4,
    parameter int unsigned F = 4,
    localparam int unsigned W     = I + F,
    localparam int unsigned LOG2N = $clog2(N),
    localparam int unsigned AW    = $clog2(N / 2),
    localparam int unsigned SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_start,
`ifdef TWIDDLE_CONJ_EN
    input  logic          i_inverse,
`endif
    output logic          o_busy,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [W-1:0]  i_rd_data_re,
    input  logic [W-1:0]  i_rd_data_im,
    output logic          o_tw_valid,
    input  logic          i_tw_ready,
    output logic [W-1:0]  o_tw_re,
    output logic [W-1:0]  o_tw_im,
    output logic [SW-1:0] o_tw_stage,
    output logic [AW-1:0] o_tw_bfly,
    output logic          o_tw_last,
    output logic          o_done
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StPresent = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    localparam logic [SW-1:0] StageLast = SW'(LOG2N - 1);
    localparam logic [AW-1:0] BflyLast  = AW'(N / 2 - 1);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [AW-1:0] bfly_q, bfly_d;
    logic [W-1:0]  re_q, re_d;
    logic [W-1:0]  im_q, im_d;
    logic [W-1:0]  cap_im;
    logic [AW-1:0] stage_mask;
    logic [AW-1:0] fetch_addr;
    int unsigned   shamt;
    logic          at_last;

`ifdef TWIDDLE_CONJ_EN
    localparam logic [W-1:0] MostNeg = {1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0] MostPos = {1'b0, {(W - 1){1'b1}}};

    logic inv_q, inv_d;

    // Conjugate on capture when the pass was started as an inverse transform
    always_comb begin
        cap_im = i_rd_data_im;
        if (inv_q) begin
            // Two's-complement negate of the most-negative code overflows; clamp it
            if (i_rd_data_im == MostNeg) begin
                cap_im = MostPos;
            end else begin
                cap_im = (~i_rd_data_im) + W'(1);
            end
        end
    end
`else
    assign cap_im = i_rd_data_im;
`endif

    // ROM index: low 'stage' bits of the butterfly, shifted up to the top of the index
    always_comb begin
        stage_mask = AW'((32'd1 << stage_q) - 32'd1);
        shamt      = LOG2N - 1 - 32'(stage_q);
        fetch_addr = (bfly_q & stage_mask) << shamt;
        at_last    = (stage_q == StageLast) && (bfly_q == BflyLast);
    end

    // Next-state logic for the FSM, counters and captured twiddle
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        re_d    = re_q;
        im_d    = im_q;
`ifdef TWIDDLE_CONJ_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StFetch;
                    stage_d = '0;
                    bfly_d  = '0;
`ifdef TWIDDLE_CONJ_EN
                    inv_d   = i_inverse;
`endif
                end
            end
            StFetch: begin
                state_d = StCapture;
            end
            StCapture: begin
                re_d    = i_rd_data_re;
                im_d    = cap_im;
                state_d = StPresent;
            end
            StPresent: begin
                if (i_tw_ready) begin
                    if (at_last) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                        if (bfly_q == BflyLast) begin
                            bfly_d  = '0;
                            stage_d = stage_q + SW'(1);
                        end else begin
                            bfly_d  = bfly_q + AW'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            stage_q <= '0;
            bfly_q  <= '0;
            re_q    <= '0;
            im_q    <= '0;
`ifdef TWIDDLE_CONJ_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            re_q    <= re_d;
            im_q    <= im_d;
`ifdef TWIDDLE_CONJ_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // Outputs decoded from state; last is only meaningful alongside valid
    always_comb begin
        o_busy     = (state_q != StIdle);
        o_rd_en    = (state_q == StFetch);
        o_rd_addr  = o_rd_en ? fetch_addr : '0;
        o_tw_valid = (state_q == StPresent);
        o_tw_last  = o_tw_valid && at_last;
        o_done     = (state_q == StDone);
        o_tw_re    = re_q;
        o_tw_im    = im_q;
        o_tw_stage = stage_q;
        o_tw_bfly  = bfly_q;
    end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed self-checking bench for twiddle_sequencer (N=8, I=4, F=4).
// Checks reset, a full pass, a stalled pass, start-while-busy and mid-pass
// reset, plus the conjugate path when TWIDDLE_CONJ_EN is defined.
module tb_twiddle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       tw_ready;
    logic       busy;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_re = 8'h00;
    logic [7:0] rd_im = 8'h00;
    logic       tw_valid;
    logic [7:0] tw_re;
    logic [7:0] tw_im;
    logic [1:0] tw_stage;
    logic [1:0] tw_bfly;
    logic       tw_last;
    logic       done;
`ifdef TWIDDLE_CONJ_EN
    logic       inverse;
`endif

    logic       rom_rand   = 1'b0;
    logic       force_im80 = 1'b0;
    logic [7:0] rom_re  [4];
    logic [7:0] rom_im  [4];
    logic [7:0] conj_im [4];
    logic [1:0] exp_addr[12];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    twiddle_sequencer #(
        .N(8),
        .I(4),
        .F(4)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
`ifdef TWIDDLE_CONJ_EN
        .i_inverse   (inverse),
`endif
        .o_busy      (busy),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .i_rd_data_re(rd_re),
        .i_rd_data_im(rd_im),
        .o_tw_valid  (tw_valid),
        .i_tw_ready  (tw_ready),
        .o_tw_re     (tw_re),
        .o_tw_im     (tw_im),
        .o_tw_stage  (tw_stage),
        .o_tw_bfly   (tw_bfly),
        .o_tw_last   (tw_last),
        .o_done      (done)
    );

    // ROM model with one-cycle registered read; can be randomised or forced
    always @(posedge clk) begin
        if (rom_rand) begin
            rd_re <= 8'($urandom);
            rd_im <= 8'($urandom);
        end else if (rd_en === 1'b1) begin
            rd_re <= rom_re[rd_addr];
            rd_im <= force_im80 ? 8'h80 : rom_im[rd_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},  32'(busy),     32'd0);
        check({tag, ".rd_en"}, 32'(rd_en),    32'd0);
        check({tag, ".addr"},  32'(rd_addr),  32'd0);
        check({tag, ".valid"}, 32'(tw_valid), 32'd0);
        check({tag, ".re"},    32'(tw_re),    32'd0);
        check({tag, ".im"},    32'(tw_im),    32'd0);
        check({tag, ".stage"}, 32'(tw_stage), 32'd0);
        check({tag, ".bfly"},  32'(tw_bfly),  32'd0);
        check({tag, ".last"},  32'(tw_last),  32'd0);
        check({tag, ".done"},  32'(done),     32'd0);
    endtask

    // One full pass started at the current negedge (cycle 0); optional stall
    task automatic run_pass(input int stall_k, input int stall_len, input logic inv);
        logic [1:0] a;
        logic [7:0] eim;
        int         nst;
        cyc      = 0;
        start    = 1'b1;
        tw_ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
        inverse  = inv;
`endif
        step();
        start = 1'b0;
`ifdef TWIDDLE_CONJ_EN
        inverse = 1'b0;
`endif
        for (int k = 0; k < 12; k++) begin
            a   = exp_addr[k];
            eim = inv ? conj_im[a] : rom_im[a];
            check("fetch.rd_en", 32'(rd_en), 32'd1);
            check("fetch.addr",  32'(rd_addr), 32'(a));
            check("fetch.valid", 32'(tw_valid), 32'd0);
            check("fetch.busy",  32'(busy), 32'd1);
            step();
            check("cap.rd_en", 32'(rd_en), 32'd0);
            check("cap.addr",  32'(rd_addr), 32'd0);
            check("cap.valid", 32'(tw_valid), 32'd0);
            check("cap.last",  32'(tw_last), 32'd0);
            step();
            nst = (k == stall_k) ? stall_len : 0;
            for (int s = 0; s <= nst; s++) begin
                tw_ready = (s == nst);
                check("pres.valid", 32'(tw_valid), 32'd1);
                check("pres.rd_en", 32'(rd_en), 32'd0);
                check("pres.re",    32'(tw_re), 32'(rom_re[a]));
                check("pres.im",    32'(tw_im), 32'(eim));
                check("pres.stage", 32'(tw_stage), 32'(k / 4));
                check("pres.bfly",  32'(tw_bfly), 32'(k % 4));
                check("pres.last",  32'(tw_last), (k == 11) ? 32'd1 : 32'd0);
                check("pres.done",  32'(done), 32'd0);
                step();
            end
            tw_ready = 1'b1;
        end
        check("done.pulse", 32'(done), 32'd1);
        check("done.busy",  32'(busy), 32'd1);
        check("done.valid", 32'(tw_valid), 32'd0);
        step();
        check("idle.done", 32'(done), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        step();
        check("idle2.done", 32'(done), 32'd0);
    endtask

    initial begin
        rom_re[0] = 8'h10; rom_im[0] = 8'h00; conj_im[0] = 8'h00;
        rom_re[1] = 8'h0D; rom_im[1] = 8'hF3; conj_im[1] = 8'h0D;
        rom_re[2] = 8'h00; rom_im[2] = 8'hF0; conj_im[2] = 8'h10;
        rom_re[3] = 8'hF3; rom_im[3] = 8'hF3; conj_im[3] = 8'h0D;
        exp_addr[0] = 2'd0; exp_addr[1]  = 2'd0; exp_addr[2]  = 2'd0; exp_addr[3]  = 2'd0;
        exp_addr[4] = 2'd0; exp_addr[5]  = 2'd2; exp_addr[6]  = 2'd0; exp_addr[7]  = 2'd2;
        exp_addr[8] = 2'd0; exp_addr[9]  = 2'd1; exp_addr[10] = 2'd2; exp_addr[11] = 2'd3;

        // Reset for three cycles with random inputs
        rst_n    = 1'b0;
        rom_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            start    = 1'($urandom);
            tw_ready = 1'($urandom);
`ifdef TWIDDLE_CONJ_EN
            inverse  = 1'($urandom);
`endif
            step();
            check_all_zero("reset");
        end
        rom_rand = 1'b0;
        start    = 1'b0;
        tw_ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
        inverse  = 1'b0;
`endif
        rst_n = 1'b1;
        step();
        check("post_reset.busy", 32'(busy), 32'd0);

        // Clean pass, then a pass stalled for 5 cycles on twiddle 5
        run_pass(-1, 0, 1'b0);
        run_pass(5, 5, 1'b0);

        // Start while busy is ignored, then reset mid-pass aborts with no done
        cyc      = 0;
        start    = 1'b1;
        tw_ready = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 10) step();
        check("busy_start.rd_en", 32'(rd_en), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("busy_start.valid", 32'(tw_valid), 32'd1);
        check("busy_start.bfly",  32'(tw_bfly), 32'd3);
        check("busy_start.stage", 32'(tw_stage), 32'd0);
        while (cyc < 20) step();
        check("pre_abort.busy", 32'(busy), 32'd1);
        check("pre_abort.im",   32'(tw_im), 32'hF0);
        rst_n = 1'b0;
        step();
        check_all_zero("abort");
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            check("abort.no_done", 32'(done), 32'd0);
            check("abort.idle",    32'(busy), 32'd0);
        end
        run_pass(-1, 0, 1'b0);

`ifdef TWIDDLE_CONJ_EN
        // Inverse pass, then a forced most-negative imaginary code saturates
        run_pass(-1, 0, 1'b1);
        force_im80 = 1'b1;
        cyc        = 0;
        inverse    = 1'b1;
        start      = 1'b1;
        step();
        start   = 1'b0;
        inverse = 1'b0;
        step();
        step();
        check("conj_sat.valid", 32'(tw_valid), 32'd1);
        check("conj_sat.im",    32'(tw_im), 32'h7F);
        check("conj_sat.re",    32'(tw_re), 32'h10);
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        force_im80 = 1'b0;
        step();
        check("conj_sat.idle", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
